// File: rtl/plot_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | plot_pkg                                                                   |
// | Shared FSM state type, width helper and sample clamp for the plotter.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package plot_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CLEAR   = 4'd1,
    READ0   = 4'd2,
    LATCH0  = 4'd3,
    READ    = 4'd4,
    LATCH   = 4'd5,
    ISSUE   = 4'd6,
    WAIT_LD = 4'd7,
    DONE    = 4'd8
  } state_t;

  // Never returns zero so that degenerate 1-pixel dimensions still give legal vectors.
  function automatic int unsigned bits_for(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic int unsigned clamp_y(input int unsigned sample, input int unsigned ver_pixels);
    return (sample >= ver_pixels) ? ver_pixels - 1 : sample;
  endfunction

endpackage
`default_nettype wire

// File: rtl/plot_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | plot_sequencer_if                                                          |
// | Control, sample RAM, line drawer and framebuffer signals of the sequencer. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface plot_sequencer_if #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int WRITE_DATA_WIDTH  = 1
);
  import plot_pkg::*;

  localparam int X_WIDTH          = int'(bits_for(HOR_ACTIVE_PIXELS));
  localparam int Y_WIDTH          = int'(bits_for(VER_ACTIVE_PIXELS));
  localparam int PIXELS_COUNT     = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
  localparam int WRITE_ADDR_WIDTH = int'(bits_for(PIXELS_COUNT));

  logic                        start;
  logic                        busy;
  logic                        done;
  logic [X_WIDTH-1:0]          sample_addr;
  logic [Y_WIDTH-1:0]          sample_data;
  logic [X_WIDTH-1:0]          ld_x1;
  logic [X_WIDTH-1:0]          ld_x2;
  logic [Y_WIDTH-1:0]          ld_y1;
  logic [Y_WIDTH-1:0]          ld_y2;
  logic                        ld_start;
  logic                        ld_ready;
  logic                        ld_write_enable;
  logic [WRITE_ADDR_WIDTH-1:0] ld_write_addr;
  logic [WRITE_DATA_WIDTH-1:0] ld_write_data;
  logic                        fb_write_enable;
  logic [WRITE_ADDR_WIDTH-1:0] fb_write_addr;
  logic [WRITE_DATA_WIDTH-1:0] fb_write_data;

  modport master (
    input  start, sample_data, ld_ready, ld_write_enable, ld_write_addr, ld_write_data,
    output busy, done, sample_addr, ld_x1, ld_x2, ld_y1, ld_y2, ld_start,
           fb_write_enable, fb_write_addr, fb_write_data
  );

  modport slave (
    output start, sample_data, ld_ready, ld_write_enable, ld_write_addr, ld_write_data,
    input  busy, done, sample_addr, ld_x1, ld_x2, ld_y1, ld_y2, ld_start,
           fb_write_enable, fb_write_addr, fb_write_data
  );

endinterface
`default_nettype wire

// File: rtl/fb_clearer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_clearer                                                                 |
// | Walks every framebuffer address once, one per cycle, after a go pulse.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fb_clearer #(
  parameter int PIXELS_COUNT = 307200,
  parameter int ADDR_WIDTH   = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  output logic                  active,
  output logic                  last,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [ADDR_WIDTH-1:0] c_addr_last = ADDR_WIDTH'(PIXELS_COUNT - 1);

  logic                  r_active;
  logic [ADDR_WIDTH-1:0] r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_addr   <= '0;
    end else if (go) begin
      r_active <= 1'b1;
      r_addr   <= '0;
    end else if (r_active) begin
      if (r_addr == c_addr_last) begin
        r_active <= 1'b0;
      end else begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
      end
    end
  end

  assign active = r_active;
  assign addr   = r_addr;
  assign last   = r_active && (r_addr == c_addr_last);

endmodule
`default_nettype wire

// File: rtl/plot_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | plot_sequencer                                                             |
// | Clears the framebuffer, then draws the sample polyline via the line drawer.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module plot_sequencer
  import plot_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int BG_COLOR          = 1,
  parameter int WRITE_DATA_WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  plot_sequencer_if.master bus
);

  localparam int X_WIDTH          = int'(bits_for(HOR_ACTIVE_PIXELS));
  localparam int Y_WIDTH          = int'(bits_for(VER_ACTIVE_PIXELS));
  localparam int PIXELS_COUNT     = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
  localparam int WRITE_ADDR_WIDTH = int'(bits_for(PIXELS_COUNT));

  localparam logic [X_WIDTH-1:0]          c_x_last = X_WIDTH'(HOR_ACTIVE_PIXELS - 1);
  localparam logic [WRITE_DATA_WIDTH-1:0] c_bg     = WRITE_DATA_WIDTH'(BG_COLOR);

  state_t                      r_state;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_ld_start;
  logic [X_WIDTH-1:0]          r_sample_addr;
  logic [X_WIDTH-1:0]          r_x;
  logic [Y_WIDTH-1:0]          r_prev_y;
  logic [Y_WIDTH-1:0]          r_cur_y;
  logic [X_WIDTH-1:0]          r_x1;
  logic [X_WIDTH-1:0]          r_x2;
  logic [Y_WIDTH-1:0]          r_y1;
  logic [Y_WIDTH-1:0]          r_y2;

  logic                        w_clr_go;
  logic                        w_clr_active;
  logic                        w_clr_last;
  logic [WRITE_ADDR_WIDTH-1:0] w_clr_addr;
  logic [Y_WIDTH-1:0]          w_sample_y;
  logic                        w_in_clear;

  assign w_clr_go   = (r_state == IDLE) && bus.start;
  assign w_sample_y = Y_WIDTH'(clamp_y(32'(bus.sample_data), VER_ACTIVE_PIXELS));

  fb_clearer #(
    .PIXELS_COUNT (PIXELS_COUNT),
    .ADDR_WIDTH   (WRITE_ADDR_WIDTH)
  ) u_clearer (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (w_clr_go),
    .active (w_clr_active),
    .last   (w_clr_last),
    .addr   (w_clr_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_ld_start    <= 1'b0;
      r_sample_addr <= '0;
      r_x           <= '0;
      r_prev_y      <= '0;
      r_cur_y       <= '0;
      r_x1          <= '0;
      r_x2          <= '0;
      r_y1          <= '0;
      r_y2          <= '0;
    end else begin
      r_done     <= 1'b0;
      r_ld_start <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= CLEAR;
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (w_clr_last) begin
            r_state       <= READ0;
            r_sample_addr <= '0;
          end
        end
        READ0: r_state <= LATCH0;
        LATCH0: begin
          r_prev_y <= w_sample_y;
          if (HOR_ACTIVE_PIXELS == 1) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_x           <= X_WIDTH'(1);
            r_sample_addr <= X_WIDTH'(1);
            r_state       <= READ;
          end
        end
        READ: r_state <= LATCH;
        LATCH: begin
          r_cur_y <= w_sample_y;
          r_state <= ISSUE;
        end
        ISSUE: begin
          if (bus.ld_ready) begin
            r_ld_start <= 1'b1;
            r_x1       <= r_x - X_WIDTH'(1);
            r_y1       <= r_prev_y;
            r_x2       <= r_x;
            r_y2       <= r_cur_y;
            r_state    <= WAIT_LD;
          end
        end
        WAIT_LD: begin
          // r_ld_start marks the launch cycle, when the drawer's ready is still stale.
          if (!r_ld_start && bus.ld_ready) begin
            r_prev_y <= r_cur_y;
            if (r_x == c_x_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_x           <= r_x + X_WIDTH'(1);
              r_sample_addr <= r_x + X_WIDTH'(1);
              r_state       <= READ;
            end
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.ld_start    = r_ld_start;
  assign bus.sample_addr = r_sample_addr;
  assign bus.ld_x1       = r_x1;
  assign bus.ld_x2       = r_x2;
  assign bus.ld_y1       = r_y1;
  assign bus.ld_y2       = r_y2;

  assign w_in_clear          = (r_state == CLEAR);
  assign bus.fb_write_enable = w_in_clear ? w_clr_active : ((r_state != IDLE) && bus.ld_write_enable);
  assign bus.fb_write_addr   = w_in_clear ? w_clr_addr : bus.ld_write_addr;
  assign bus.fb_write_data   = w_in_clear ? c_bg : bus.ld_write_data;

endmodule
`default_nettype wire
